// File: rtl/ft_router_pkg.sv
// Shared definitions for the FTDI stream router: FSM states, header field
// extraction and the default header-forwarding mask.
package ft_router_pkg;

  typedef enum logic [1:0] {
    ST_HDR  = 2'd0,
    ST_PAY  = 2'd1,
    ST_DROP = 2'd2
  } state_e;

  localparam int unsigned HDR_MAX_W = 64;

  // Sink 1 (ECPU mailbox) needs to see the header word.
  localparam logic [7:0] HDR_FWD_MASK_DEFAULT = 8'b0000_0010;

  // Fields are extracted from a zero-extended word so one function serves any DATA_W.
  function automatic logic [HDR_MAX_W-1:0] hdr_dest_field(input logic [HDR_MAX_W-1:0] word,
                                                          input int unsigned data_w,
                                                          input int unsigned dest_bits);
    return (word >> (data_w - dest_bits)) & ((HDR_MAX_W'(1) << dest_bits) - HDR_MAX_W'(1));
  endfunction

  function automatic logic [HDR_MAX_W-1:0] hdr_len_field(input logic [HDR_MAX_W-1:0] word,
                                                         input int unsigned len_w);
    return word & ((HDR_MAX_W'(1) << len_w) - HDR_MAX_W'(1));
  endfunction

endpackage

// File: rtl/ft_hdr_decode.sv
// Combinational header decode: destination field, payload length and
// whether the destination names an existing sink.
module ft_hdr_decode
  import ft_router_pkg::*;
#(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned NUM_DEST  = 2,
  parameter int unsigned DEST_BITS = 3,
  parameter int unsigned LEN_W     = 16
) (
  input  logic [DATA_W-1:0]    data_i,
  output logic [DEST_BITS-1:0] dest_o,
  output logic [LEN_W-1:0]     len_o,
  output logic                 dest_valid_o
);

  always_comb begin
    dest_o       = DEST_BITS'(hdr_dest_field(HDR_MAX_W'(data_i), DATA_W, DEST_BITS));
    len_o        = LEN_W'(hdr_len_field(HDR_MAX_W'(data_i), LEN_W));
    dest_valid_o = (32'(dest_o) < NUM_DEST);
  end

endmodule

// File: rtl/ft_stream_router.sv
// Routes FTDI write-stream packets (header + payload) to one of NUM_DEST sinks,
// with per-sink backpressure, header forwarding, invalid-dest drop and loopback.
module ft_stream_router
  import ft_router_pkg::*;
#(
  parameter int unsigned          DATA_W       = 32,
  parameter int unsigned          NUM_DEST     = 2,
  parameter int unsigned          DEST_BITS    = 3,
  parameter int unsigned          LEN_W        = 16,
  parameter logic [NUM_DEST-1:0]  HDR_FWD_MASK = NUM_DEST'(HDR_FWD_MASK_DEFAULT),
  parameter int unsigned          ERR_W        = 8
) (
  input  logic                clk_i,
  input  logic                reset_n,
  input  logic                loopback_i,
  input  logic [DATA_W-1:0]   data_i,
  input  logic                we_i,
  output logic                full_o,
  input  logic [NUM_DEST-1:0] dst_full_i,
  output logic [DATA_W-1:0]   dst_data_o,
  output logic [NUM_DEST-1:0] dst_we_o,
  output logic                busy_o,
  output logic                pkt_done_o,
  output logic [ERR_W-1:0]    err_cnt_o
);

  localparam int unsigned SEL_W = $clog2(NUM_DEST);
  localparam logic [NUM_DEST-1:0] ONE = NUM_DEST'(1);

  if (DEST_BITS + LEN_W > DATA_W) begin : g_field_overlap
    $error("ft_stream_router: DEST_BITS + LEN_W exceeds DATA_W, header fields overlap");
  end
  if (NUM_DEST < 2 || NUM_DEST > 8) begin : g_bad_num_dest
    $error("ft_stream_router: NUM_DEST must be in 2..8");
  end

  state_e              state_q, state_d;
  logic [LEN_W-1:0]    rem_q, rem_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic [DATA_W-1:0]   dst_data_q, dst_data_d;
  logic [NUM_DEST-1:0] dst_we_q, dst_we_d;
  logic                pkt_done_q, pkt_done_d;
  logic [ERR_W-1:0]    err_cnt_q, err_cnt_d;

  logic [DEST_BITS-1:0] hdr_dest;
  logic [LEN_W-1:0]     hdr_len;
  logic                 hdr_valid;
  logic                 accept;

  ft_hdr_decode #(
    .DATA_W   (DATA_W),
    .NUM_DEST (NUM_DEST),
    .DEST_BITS(DEST_BITS),
    .LEN_W    (LEN_W)
  ) u_hdr_decode (
    .data_i      (data_i),
    .dest_o      (hdr_dest),
    .len_o       (hdr_len),
    .dest_valid_o(hdr_valid)
  );

  always_comb begin
    full_o = 1'b0;
    if (loopback_i)            full_o = dst_full_i[0];
    else if (state_q == ST_PAY) full_o = dst_full_i[sel_q];
  end

  assign accept = we_i & ~full_o;

  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    sel_d      = sel_q;
    dst_data_d = dst_data_q;
    dst_we_d   = '0;
    pkt_done_d = 1'b0;
    err_cnt_d  = err_cnt_q;

    if (accept) dst_data_d = data_i;

    if (loopback_i) begin
      state_d = ST_HDR;
      rem_d   = '0;
      if (accept) dst_we_d = ONE;
    end else if (accept) begin
      unique case (state_q)
        ST_HDR: begin
          if (hdr_valid) begin
            sel_d = SEL_W'(hdr_dest);
            if (|(HDR_FWD_MASK & (ONE << hdr_dest))) dst_we_d = ONE << hdr_dest;
            if (hdr_len == '0) begin
              pkt_done_d = 1'b1;
            end else begin
              rem_d   = hdr_len;
              state_d = ST_PAY;
            end
          end else begin
            if (err_cnt_q != '1) err_cnt_d = err_cnt_q + ERR_W'(1);
            if (hdr_len != '0) begin
              rem_d   = hdr_len;
              state_d = ST_DROP;
            end
          end
        end
        ST_PAY: begin
          dst_we_d = ONE << sel_q;
          rem_d    = rem_q - LEN_W'(1);
          if (rem_q == LEN_W'(1)) begin
            pkt_done_d = 1'b1;
            state_d    = ST_HDR;
          end
        end
        ST_DROP: begin
          rem_d = rem_q - LEN_W'(1);
          if (rem_q == LEN_W'(1)) state_d = ST_HDR;
        end
        default: begin
          state_d = ST_HDR;
          rem_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_HDR;
      rem_q      <= '0;
      sel_q      <= '0;
      dst_data_q <= '0;
      dst_we_q   <= '0;
      pkt_done_q <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      sel_q      <= sel_d;
      dst_data_q <= dst_data_d;
      dst_we_q   <= dst_we_d;
      pkt_done_q <= pkt_done_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign dst_data_o = dst_data_q;
  assign dst_we_o   = dst_we_q;
  assign pkt_done_o = pkt_done_q;
  assign err_cnt_o  = err_cnt_q;
  assign busy_o     = (state_q == ST_PAY) || (state_q == ST_DROP);

endmodule
